// File: rtl/fl_pkg.sv
// Shared constants and helpers for the rename-stage free list.
// Default sizing of the physical/architectural register files.
package fl_pkg;

    localparam int FL_NUM_PR   = 64;
    localparam int FL_NUM_AR   = 32;
    localparam int FL_PR_WIDTH = 7;

    // Number of tags a buffer holding n free entries can hand out.
    function automatic logic [1:0] fl_min2(input logic [31:0] n);
        return (n >= 32'd2) ? 2'd2 : n[1:0];
    endfunction

endpackage

// File: rtl/fl.sv
// Physical-register free list: circular buffer of free PR tags for a
// 2-wide rename stage, with retire-time reclaim and one-cycle squash.
//
// Ports:
//   clock, reset               posedge clock, synchronous active-high reset
//   rob_dispatch_num           tags allocated this cycle (0..2)
//   rob_retire_num             tags freed this cycle (0..2), slot 0 first
//   rob_told0, rob_told1       freed (old) tags
//   rob_mispredict             restore every in-flight allocation
//   fl_pr0, fl_pr1             tags at head and head+1
//   fl_avail_num               min(count, 2)
module fl
    import fl_pkg::*;
#(
    parameter int NUM_PR   = FL_NUM_PR,
    parameter int NUM_AR   = FL_NUM_AR,
    parameter int FL_DEPTH = NUM_PR - NUM_AR,
    parameter int PR_WIDTH = FL_PR_WIDTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          rob_dispatch_num,
    input  logic [1:0]          rob_retire_num,
    input  logic [PR_WIDTH-1:0] rob_told0,
    input  logic [PR_WIDTH-1:0] rob_told1,
    input  logic                rob_mispredict,
    output logic [PR_WIDTH-1:0] fl_pr0,
    output logic [PR_WIDTH-1:0] fl_pr1,
    output logic [1:0]          fl_avail_num
);

    localparam int PTR_W = $clog2(FL_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PR_WIDTH-1:0] entries_q [FL_DEPTH];
    logic [PR_WIDTH-1:0] entries_d [FL_DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    // Wrapped neighbours; pointer width gives the modulo for free.
    logic [PTR_W-1:0]    head_p1;
    logic [PTR_W-1:0]    tail_p1;

    assign head_p1 = head_q + PTR_W'(1);
    assign tail_p1 = tail_q + PTR_W'(1);

    // Outputs depend on registered state only.
    assign fl_pr0       = entries_q[head_q];
    assign fl_pr1       = entries_q[head_p1];
    assign fl_avail_num = fl_min2(32'(count_q));

    always_comb begin
        entries_d = entries_q;
        if (rob_retire_num >= 2'd1) begin
            entries_d[tail_q] = rob_told0;
        end
        if (rob_retire_num == 2'd2) begin
            entries_d[tail_p1] = rob_told1;
        end
        tail_d = tail_q + PTR_W'(rob_retire_num);

        if (rob_mispredict) begin
            // Everything between the retired tail and head goes back
            // to the free region; the dispatch request is dropped.
            head_d  = tail_d;
            count_d = CNT_W'(FL_DEPTH);
        end else begin
            head_d  = head_q + PTR_W'(rob_dispatch_num);
            count_d = count_q + CNT_W'(rob_retire_num)
                              - CNT_W'(rob_dispatch_num);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entries_q[i] <= PR_WIDTH'(NUM_AR + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(FL_DEPTH);
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    a_num_legal: assert property (@(posedge clock) disable iff (reset)
        rob_dispatch_num != 2'd3 && rob_retire_num != 2'd3);

    a_no_overalloc: assert property (@(posedge clock) disable iff (reset)
        rob_mispredict || rob_dispatch_num <= fl_avail_num);

    a_no_overfree: assert property (@(posedge clock) disable iff (reset)
        (int'(count_q) + int'(rob_retire_num)) <= FL_DEPTH);

endmodule
